// File: rtl/pcf8591_scan_ctrl_if.sv
// Command/response link between the PCF8591 scan sequencer (master) and a byte-level I2C engine (slave).
// One command is outstanding at a time. rsp_valid is a one-cycle completion pulse.
interface pcf8591_scan_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_read;
  logic       cmd_ack;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;

  modport master (
    output cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_ack, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_ack, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack
  );
endinterface

// File: rtl/pcf8591_scan_ctrl.sv
// Periodic masked scan of PCF8591 inputs over a byte-level I2C master; PCF_AVG_EN averages 4 reads per channel.
// Latency: sample_valid one cycle after the final data-read response; one command in flight at a time.
// Backpressure: cmd_* held stable until cmd_ready; next command waits for rsp_valid.
module pcf8591_scan_ctrl #(
  parameter logic [6:0] DEV_ADDR    = 7'h48,
  parameter int         NUM_CH      = 4,
  parameter int         SCAN_PERIOD = 1000,
  parameter int         CW          = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  pcf8591_scan_ctrl_if.master i2c,
  output logic              sample_valid,
  output logic [CW-1:0]     sample_ch,
  output logic [7:0]        sample_data,
  output logic              busy,
  output logic              nack_err
);

  localparam int PW = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;

`ifdef PCF_AVG_EN
  localparam logic FIRST_LAST = 1'b0;
`else
  localparam logic FIRST_LAST = 1'b1;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, NEXT} stateT;
  typedef enum logic [2:0] {ADDR_W, CTRL, ADDR_R, RD_DUMMY, RD_DATA, RECOVER} stepT;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       ack;
    logic [7:0] wdata;
  } cmdT;

  function automatic cmdT cmdFor(stepT s, logic [CW-1:0] c, logic lastRd);
    cmdT r;
    r = '0;
    case (s)
      ADDR_W:   begin r.start = 1'b1; r.wdata = {DEV_ADDR, 1'b0}; end
      CTRL:     r.wdata = 8'h40 | 8'(c);
      ADDR_R:   begin r.start = 1'b1; r.wdata = {DEV_ADDR, 1'b1}; end
      RD_DUMMY: begin r.read = 1'b1; r.ack = 1'b1; end
      RD_DATA:  begin r.read = 1'b1; r.ack = !lastRd; r.stop = lastRd; end
      default:  begin r.stop = 1'b1; r.wdata = 8'hFF; end
    endcase
    return r;
  endfunction

  // {found, index} of the lowest set mask bit at or above start
  function automatic logic [CW:0] findFrom(logic [NUM_CH-1:0] m, int start);
    logic [CW:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i >= start && m[i]) r = {1'b1, CW'(i)};
    end
    return r;
  endfunction

  stateT             state;
  stepT              step;
  stepT              okNext;
  logic [PW-1:0]     periodCnt;
  logic              tick;
  logic [NUM_CH-1:0] maskLat;
  logic [CW-1:0]     chPtr;
  logic              cmdValid;
  cmdT               cmdReg;
  logic [CW:0]       firstHit;
  logic [CW:0]       nextHit;

`ifdef PCF_AVG_EN
  logic [1:0]        avgCnt;
  logic [9:0]        avgSum;
  logic [9:0]        sumNext;
  assign sumNext = avgSum + 10'(i2c.rsp_data);
`endif

  assign tick     = (periodCnt == PW'(SCAN_PERIOD - 1));
  assign firstHit = findFrom(ch_mask, 0);
  assign nextHit  = findFrom(maskLat, int'(chPtr) + 1);
  assign okNext   = (step == ADDR_W) ? CTRL : (step == CTRL) ? ADDR_R : RD_DUMMY;

  assign i2c.cmd_valid = cmdValid;
  assign i2c.cmd_start = cmdReg.start;
  assign i2c.cmd_stop  = cmdReg.stop;
  assign i2c.cmd_read  = cmdReg.read;
  assign i2c.cmd_ack   = cmdReg.ack;
  assign i2c.cmd_wdata = cmdReg.wdata;

  always_ff @(posedge clk) begin
    if (reset || tick) periodCnt <= '0;
    else               periodCnt <= periodCnt + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      step         <= ADDR_W;
      chPtr        <= '0;
      maskLat      <= '0;
      cmdValid     <= 1'b0;
      cmdReg       <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      busy         <= 1'b0;
      nack_err     <= 1'b0;
`ifdef PCF_AVG_EN
      avgCnt       <= '0;
      avgSum       <= '0;
`endif
    end else begin
      sample_valid <= 1'b0;
      nack_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && enable && |ch_mask) begin
            maskLat  <= ch_mask;
            busy     <= 1'b1;
            chPtr    <= firstHit[CW-1:0];
            step     <= ADDR_W;
            cmdReg   <= cmdFor(ADDR_W, firstHit[CW-1:0], 1'b1);
            cmdValid <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (i2c.cmd_ready) begin
            cmdValid <= 1'b0;
            state    <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (i2c.rsp_valid) begin
            case (step)
              ADDR_W, CTRL, ADDR_R: begin
                // a NACKed write is closed with a STOP-only dummy and the channel is skipped
                if (i2c.rsp_nack) begin
                  nack_err <= 1'b1;
                  step     <= RECOVER;
                  cmdReg   <= cmdFor(RECOVER, chPtr, 1'b1);
                end else begin
                  step     <= okNext;
                  cmdReg   <= cmdFor(okNext, chPtr, 1'b1);
                end
                cmdValid <= 1'b1;
                state    <= ISSUE;
              end
              RD_DUMMY: begin
                step     <= RD_DATA;
                cmdReg   <= cmdFor(RD_DATA, chPtr, FIRST_LAST);
                cmdValid <= 1'b1;
                state    <= ISSUE;
`ifdef PCF_AVG_EN
                avgCnt   <= '0;
                avgSum   <= '0;
`endif
              end
              RD_DATA: begin
`ifdef PCF_AVG_EN
                if (avgCnt == 2'd3) begin
                  sample_valid <= 1'b1;
                  sample_ch    <= chPtr;
                  sample_data  <= sumNext[9:2];
                  state        <= NEXT;
                end else begin
                  avgCnt   <= avgCnt + 2'd1;
                  avgSum   <= sumNext;
                  cmdReg   <= cmdFor(RD_DATA, chPtr, avgCnt == 2'd2);
                  cmdValid <= 1'b1;
                  state    <= ISSUE;
                end
`else
                sample_valid <= 1'b1;
                sample_ch    <= chPtr;
                sample_data  <= i2c.rsp_data;
                state        <= NEXT;
`endif
              end
              default: state <= NEXT;
            endcase
          end
        end
        default: begin
          if (nextHit[CW]) begin
            chPtr    <= nextHit[CW-1:0];
            step     <= ADDR_W;
            cmdReg   <= cmdFor(ADDR_W, nextHit[CW-1:0], 1'b1);
            cmdValid <= 1'b1;
            state    <= ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcf8591_scan_ctrl.sv
// Directed bench for pcf8591_scan_ctrl: I2C master/ADC model, protocol monitor and hand-computed expectations.
`timescale 1ns/1ps
module tb_pcf8591_scan_ctrl;
  localparam int SP = 100;
`ifdef PCF_AVG_EN
  localparam int AVG_OFS = 1;   // mean of base..base+3 truncates to base+1
`else
  localparam int AVG_OFS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] ch_mask = 4'b0000;
  logic       sample_valid;
  logic [1:0] sample_ch;
  logic [7:0] sample_data;
  logic       busy;
  logic       nack_err;

  pcf8591_scan_ctrl_if ifc ();

  pcf8591_scan_ctrl #(
    .DEV_ADDR(7'h48), .NUM_CH(4), .SCAN_PERIOD(SP), .CW(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask), .i2c(ifc),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .busy(busy), .nack_err(nack_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // master / ADC model state
  int         readyDelay = 2;
  int         nackOnAddrW = 0;
  int         addrWCnt = 0;
  bit         afterAddrR = 0;
  logic [1:0] selCh = 2'd0;
  int         rdIdx = 0;
  logic [7:0] adcBase [4] = '{8'h10, 8'h20, 8'h30, 8'h40};

  // logs
  logic [7:0] writeLog [$];
  logic [1:0] sampCh [$];
  logic [7:0] sampData [$];
  int         stopDummyCnt = 0;
  int         cmdCnt = 0;
  int         nackCnt = 0;
  int         holdViol = 0;
  int         overlapViol = 0;
  int         maxStall = 0;

  task automatic clearLogs();
    writeLog.delete();
    sampCh.delete();
    sampData.delete();
    stopDummyCnt = 0;
    cmdCnt = 0;
    nackCnt = 0;
    addrWCnt = 0;
  endtask

  initial begin
    logic [7:0] rdat;
    logic       rnack;
    logic       cStart, cStop, cRead;
    logic [7:0] cWdata;
    ifc.cmd_ready = 1'b0;
    ifc.rsp_valid = 1'b0;
    ifc.rsp_data  = 8'h00;
    ifc.rsp_nack  = 1'b0;
    forever begin
      @(posedge clk); #1;
      ifc.rsp_valid = 1'b0;
      ifc.rsp_nack  = 1'b0;
      ifc.rsp_data  = 8'h00;
      if (ifc.cmd_valid && !reset) begin
        for (int k = 0; k < readyDelay; k++) begin @(posedge clk); #1; end
        if (ifc.cmd_valid && !reset) begin
          ifc.cmd_ready = 1'b1;
          cStart = ifc.cmd_start; cStop = ifc.cmd_stop;
          cRead  = ifc.cmd_read;  cWdata = ifc.cmd_wdata;
          @(posedge clk); #1;
          ifc.cmd_ready = 1'b0;
          cmdCnt++;
          rdat = 8'h00;
          rnack = 1'b0;
          if (!cRead) begin
            writeLog.push_back(cWdata);
            if (cStop && !cStart && cWdata == 8'hFF) stopDummyCnt++;
            if (cStart && !cWdata[0]) begin
              addrWCnt++;
              if (addrWCnt == nackOnAddrW) rnack = 1'b1;
            end else if (cStart) begin
              afterAddrR = 1;
              rdIdx = 0;
            end else if (cWdata[7:2] == 6'b010000) begin
              selCh = cWdata[1:0];
            end
          end else if (afterAddrR) begin
            rdat = 8'hEE;
            afterAddrR = 0;
          end else begin
            rdat = adcBase[selCh] + 8'(rdIdx);
            rdIdx++;
          end
          @(posedge clk);
          @(posedge clk); #1;
          if (!reset) begin
            ifc.rsp_valid = 1'b1;
            ifc.rsp_data  = rdat;
            ifc.rsp_nack  = rnack;
          end
        end
      end
    end
  end

  // protocol monitor and sample collector
  initial begin
    logic [12:0] prevCmd;
    logic [12:0] curCmd;
    bit          prevHold;
    bit          outstanding;
    int          stall;
    prevCmd = '0; prevHold = 0; outstanding = 0; stall = 0;
    forever begin
      @(negedge clk);
      curCmd = {ifc.cmd_valid, ifc.cmd_start, ifc.cmd_stop, ifc.cmd_read, ifc.cmd_ack, ifc.cmd_wdata};
      if (sample_valid) begin
        sampCh.push_back(sample_ch);
        sampData.push_back(sample_data);
      end
      if (nack_err) nackCnt++;
      if (reset) begin
        prevHold = 0; outstanding = 0; stall = 0;
      end else begin
        if (prevHold && curCmd != prevCmd) holdViol++;
        if (ifc.cmd_valid && outstanding) overlapViol++;
        if (ifc.cmd_valid && ifc.cmd_ready) outstanding = 1;
        if (ifc.rsp_valid) outstanding = 0;
        prevHold = ifc.cmd_valid && !ifc.cmd_ready;
        prevCmd  = curCmd;
        stall    = prevHold ? stall + 1 : 0;
        if (stall > maxStall) maxStall = stall;
      end
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    checkVal("scanEnd", busy, 1'b0);
  endtask

  task automatic runScan(input logic [3:0] m);
    int n;
    n = 0;
    ch_mask = m;
    enable = 1'b1;
    while (!busy && n < 3000) begin @(negedge clk); n++; end
    checkVal("scanStart", busy, 1'b1);
    enable  = 1'b0;
    ch_mask = ~m;
    waitIdle();
  endtask

  initial begin
    logic [7:0] ctrlBytes [$];
    int  n;
    bit  found;
    logic [7:0] expByte;

    repeat (3) @(negedge clk);
    checkVal("rst_cmd_valid", ifc.cmd_valid, 1'b0);
    checkVal("rst_busy", busy, 1'b0);
    checkVal("rst_sample_valid", sample_valid, 1'b0);
    checkVal("rst_sample_ch", sample_ch, 2'd0);
    checkVal("rst_sample_data", sample_data, 8'h00);
    checkVal("rst_nack_err", nack_err, 1'b0);
    clearLogs();
    reset = 1'b0;

    // full mask
    runScan(4'b1111);
    checkVal("t1_nsamp", sampCh.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < sampCh.size()) begin
        checkVal($sformatf("t1_ch%0d", i), sampCh[i], i);
        checkVal($sformatf("t1_data%0d", i), sampData[i], 8'h10 * (i + 1) + AVG_OFS);
      end
    end
    checkVal("t1_nwrites", writeLog.size(), 12);
    for (int i = 0; i < 12; i++) begin
      expByte = (i % 3 == 0) ? 8'h90 : (i % 3 == 1) ? 8'(8'h40 + i / 3) : 8'h91;
      if (i < writeLog.size()) checkVal($sformatf("t1_byte%0d", i), writeLog[i], expByte);
    end
    repeat (2 * SP) @(negedge clk);
    checkVal("t1_noRescanWhenDisabled", sampCh.size(), 4);
    checkVal("t1_busyIdle", busy, 1'b0);

    // sparse mask
    clearLogs();
    runScan(4'b0101);
    checkVal("t2_nsamp", sampCh.size(), 2);
    if (sampCh.size() == 2) begin
      checkVal("t2_ch_a", sampCh[0], 2'd0);
      checkVal("t2_ch_b", sampCh[1], 2'd2);
      checkVal("t2_data_b", sampData[1], 8'h30 + AVG_OFS);
    end
    foreach (writeLog[i]) if (writeLog[i] != 8'h90 && writeLog[i] != 8'h91) ctrlBytes.push_back(writeLog[i]);
    checkVal("t2_nctrl", ctrlBytes.size(), 2);
    if (ctrlBytes.size() == 2) begin
      checkVal("t2_ctrl_a", ctrlBytes[0], 8'h40);
      checkVal("t2_ctrl_b", ctrlBytes[1], 8'h42);
    end

    // NACK on the ADDR_W of ch1
    clearLogs();
    nackOnAddrW = 2;
    runScan(4'b0011);
    nackOnAddrW = 0;
    checkVal("t3_nackPulses", nackCnt, 1);
    checkVal("t3_stopDummy", stopDummyCnt, 1);
    checkVal("t3_nsamp", sampCh.size(), 1);
    if (sampCh.size() == 1) checkVal("t3_ch", sampCh[0], 2'd0);
    checkVal("t3_ncmds", cmdCnt, 7 + 3 * AVG_OFS);
    checkVal("t3_nwrites", writeLog.size(), 5);
    if (writeLog.size() == 5) checkVal("t3_lastByte", writeLog[4], 8'hFF);

    // long cmd_ready stall
    clearLogs();
    readyDelay = 20;
    runScan(4'b0001);
    readyDelay = 2;
    checkVal("t4_stallSeen", maxStall >= 20, 1'b1);
    checkVal("t4_nsamp", sampCh.size(), 1);
    if (sampCh.size() == 1) checkVal("t4_data", sampData[0], 8'h10 + AVG_OFS);
    checkVal("holdViolations", holdViol, 0);
    checkVal("overlapViolations", overlapViol, 0);

    // reset during RD_DUMMY
    clearLogs();
    ch_mask = 4'b1111;
    enable = 1'b1;
    found = 0;
    n = 0;
    while (!found && n < 3000) begin
      @(negedge clk);
      n++;
      found = ifc.cmd_valid && ifc.cmd_read && ifc.cmd_ack;
    end
    checkVal("t5_reachDummy", found, 1'b1);
    reset = 1'b1;
    sampCh.delete();
    sampData.delete();
    @(negedge clk);
    checkVal("t5_cmdValidDrop", ifc.cmd_valid, 1'b0);
    checkVal("t5_busyDrop", busy, 1'b0);
    checkVal("t5_noSamplePulse", sample_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    checkVal("t5_noSampleInReset", sampCh.size(), 0);
    clearLogs();
    n = 0;
    while (!busy && n < 3000) begin @(negedge clk); n++; end
    checkVal("t5_firstTickDelay", n, SP);
    enable = 1'b0;
    waitIdle();
    checkVal("t5_nsamp", sampCh.size(), 4);
    if (sampCh.size() > 0) checkVal("t5_firstCh", sampCh[0], 2'd0);
    if (writeLog.size() > 1) begin
      checkVal("t5_firstByte", writeLog[0], 8'h90);
      checkVal("t5_firstCtrl", writeLog[1], 8'h40);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
